// File: rtl/mini_cpu_control_unit.sv
// Hardwired fetch/decode/execute sequencer for the mini-CPU datapath; strobes are a combinational decode of state and latched opcode.
// Optional CU_ILLEGAL_TRAP_EN: unlisted opcodes halt and set the sticky illegal flag (otherwise they run as nop).
module mini_cpu_control_unit #(
    parameter int OPW         = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic           Clock,
    input  logic           clear,
    input  logic [31:0]    ir,
    input  logic           mem_ready,
    input  logic           Stop,
    output logic           Run,
    output logic           mem_err,
    output logic           illegal,
    output logic [OPW-1:0] op,
    output logic           PCout,
    output logic           MARin,
    output logic           IncPC,
    output logic           PCin,
    output logic           Read,
    output logic           MDRin,
    output logic           MDRout,
    output logic           IRin,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           Rout,
    output logic           BAOut,
    output logic           Cout,
    output logic           Yin,
    output logic           ZHighin,
    output logic           Zlowin,
    output logic           Zhighout,
    output logic           Zlowout,
    output logic           HIin,
    output logic           LOin,
    output logic           HIOut,
    output logic           LOout
);
    localparam logic [3:0] S_RESET = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
                           S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_PAUSE = 4'd8, S_HALT = 4'd9;

    localparam logic [OPW-1:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b00101, OP_OR = 5'b00110,
                               OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI = 5'b01110,
                               OP_MUL = 5'b01111, OP_DIV = 5'b10000, OP_MFHI = 5'b10111,
                               OP_MFLO = 5'b11000, OP_NOP = 5'b11001, OP_HALT = 5'b11010;
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [3:0]     state, nxt;
    logic [OPW-1:0] opc, dec;
    logic [CW-1:0]  t1_cnt;
    logic           t1_seen, set_mem_err, last_step;
    logic           cls_r, cls_i, cls_m;
    logic           unused_ir;

    assign dec       = ir[31:32-OPW];
    assign unused_ir = ^ir[31-OPW:0];
    assign cls_r     = (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_OR);
    assign cls_i     = (opc == OP_ADDI) || (opc == OP_ANDI) || (opc == OP_ORI);
    assign cls_m     = (opc == OP_MUL) || (opc == OP_DIV);

    function automatic logic needs_exec(input logic [OPW-1:0] c);
        return (c == OP_ADD) || (c == OP_SUB) || (c == OP_AND) || (c == OP_OR) ||
               (c == OP_ADDI) || (c == OP_ANDI) || (c == OP_ORI) || (c == OP_MUL) ||
               (c == OP_DIV) || (c == OP_MFHI) || (c == OP_MFLO);
    endfunction

`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal_q, set_ill;
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (clear) begin
            state   <= S_RESET;
            opc     <= '0;
            t1_cnt  <= '0;
            t1_seen <= 1'b0;
            mem_err <= 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state <= nxt;
            if (state == S_T2)
                opc <= dec;
            // Counter and first-cycle flag both track the current T1 residency only
            if (state == S_T1) begin
                t1_cnt  <= t1_cnt + CW'(1);
                t1_seen <= 1'b1;
            end else begin
                t1_cnt  <= '0;
                t1_seen <= 1'b0;
            end
            if (set_mem_err)
                mem_err <= 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
            if (set_ill)
                illegal_q <= 1'b1;
`endif
        end
    end

    always_comb begin
        nxt         = state;
        set_mem_err = 1'b0;
        last_step   = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
        set_ill     = 1'b0;
`endif
        case (state)
            S_RESET: nxt = S_T0;
            S_T0:    nxt = S_T1;
            S_T1: begin
                if (mem_ready)
                    nxt = S_T2;
                else if (t1_cnt == CW'(MEM_TIMEOUT - 1)) begin
                    nxt         = S_HALT;
                    set_mem_err = 1'b1;
                end
            end
            // Opcode register is not loaded yet, so T2 decides from the live bus value
            S_T2: begin
                if (needs_exec(dec))
                    nxt = S_T3;
                else if (dec == OP_HALT)
                    nxt = S_HALT;
                else if (dec == OP_NOP)
                    last_step = 1'b1;
                else begin
`ifdef CU_ILLEGAL_TRAP_EN
                    nxt     = S_HALT;
                    set_ill = 1'b1;
`else
                    last_step = 1'b1;
`endif
                end
            end
            S_T3: begin
                if (cls_r || cls_i || cls_m)
                    nxt = S_T4;
                else
                    last_step = 1'b1;
            end
            S_T4: nxt = S_T5;
            S_T5: begin
                if (cls_m)
                    nxt = S_T6;
                else
                    last_step = 1'b1;
            end
            S_T6:    last_step = 1'b1;
            S_PAUSE: if (!Stop) nxt = S_T0;
            S_HALT:  nxt = S_HALT;
            default: nxt = S_RESET;
        endcase
        if (last_step)
            nxt = Stop ? S_PAUSE : S_T0;
    end

    always_comb begin
        op = '0;
        {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin} = '0;
        {Gra, Grb, Grc, Rin, Rout, BAOut, Cout, Yin} = '0;
        {ZHighin, Zlowin, Zhighout, Zlowout, HIin, LOin, HIOut, LOout} = '0;
        Run = (state >= S_T0) && (state <= S_T6);
        case (state)
            S_T0: {PCout, MARin, IncPC, ZHighin, Zlowin} = '1;
            S_T1: begin
                {Read, MDRin} = '1;
                if (!t1_seen)
                    {Zlowout, PCin} = '1;
            end
            S_T2: {MDRout, IRin} = '1;
            S_T3: begin
                if (cls_r)              {Grb, Rout, Yin} = '1;
                else if (cls_i)         {Grb, BAOut, Yin} = '1;
                else if (cls_m)         {Gra, Rout, Yin} = '1;
                else if (opc == OP_MFHI) {HIOut, Gra, Rin} = '1;
                else if (opc == OP_MFLO) {LOout, Gra, Rin} = '1;
            end
            S_T4: begin
                {ZHighin, Zlowin} = '1;
                if (cls_i) begin
                    Cout = 1'b1;
                    op   = (opc == OP_ADDI) ? OP_ADD : (opc == OP_ANDI) ? OP_AND : OP_OR;
                end else begin
                    {Rout, Grc, Grb} = {1'b1, cls_r, cls_m};
                    op = opc;
                end
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (cls_m) LOin = 1'b1;
                else       {Gra, Rin} = '1;
            end
            S_T6: {Zhighout, HIin} = '1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mini_cpu_control_unit.sv
// Bench for mini_cpu_control_unit: directed table of instruction lengths, then a micro-program queue model driven with random instructions.
module tb_mini_cpu_control_unit;
    logic        Clock = 1'b0, clear, mem_ready, Stop;
    logic [31:0] ir;
    logic        Run, mem_err, illegal;
    logic [4:0]  op;
    logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
    logic Gra, Grb, Grc, Rin, Rout, BAOut, Cout, Yin;
    logic ZHighin, Zlowin, Zhighout, Zlowout, HIin, LOin, HIOut, LOout;

    mini_cpu_control_unit #(.OPW(5), .MEM_TIMEOUT(15)) dut (
        .Clock(Clock), .clear(clear), .ir(ir), .mem_ready(mem_ready), .Stop(Stop),
        .Run(Run), .mem_err(mem_err), .illegal(illegal), .op(op),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAOut(BAOut),
        .Cout(Cout), .Yin(Yin),
        .ZHighin(ZHighin), .Zlowin(Zlowin), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIin(HIin), .LOin(LOin), .HIOut(HIOut), .LOout(LOout)
    );

    always #5 Clock = ~Clock;

    logic [31:0] obs;
    assign obs = {illegal, mem_err, Run, op, LOout, HIOut, LOin, HIin, Zlowout, Zhighout, Zlowin, ZHighin,
                  Yin, Cout, BAOut, Rout, Rin, Grc, Grb, Gra, IRin, MDRout, MDRin, Read, PCin, IncPC, MARin, PCout};

    localparam logic [23:0] PCO = 24'd1 << 0, MAR = 24'd1 << 1, INC = 24'd1 << 2, PCI = 24'd1 << 3,
        RD = 24'd1 << 4, MDI = 24'd1 << 5, MDO = 24'd1 << 6, IRI = 24'd1 << 7,
        GA = 24'd1 << 8, GB = 24'd1 << 9, GC = 24'd1 << 10, RIN = 24'd1 << 11, ROUT = 24'd1 << 12,
        BAO = 24'd1 << 13, CO = 24'd1 << 14, YI = 24'd1 << 15, ZHI = 24'd1 << 16, ZLI = 24'd1 << 17,
        ZHO = 24'd1 << 18, ZLO = 24'd1 << 19, HII = 24'd1 << 20, LOI = 24'd1 << 21, HIO = 24'd1 << 22,
        LOO = 24'd1 << 23;

    localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, AND_ = 5'b00101, OR_ = 5'b00110,
        ADDI = 5'b01100, ANDI = 5'b01101, ORI = 5'b01110, MUL = 5'b01111, DIV = 5'b10000,
        MFHI = 5'b10111, MFLO = 5'b11000, NOP = 5'b11001, HLT = 5'b11010;

    int n_checks = 0, n_pass = 0;
    logic exp_merr = 1'b0, exp_ill = 1'b0;
    logic [31:0] exp_q[$];
    logic        mr_q[$];
    logic        halted;

    typedef struct {
        logic [4:0]  opc;
        int          waits;
        int          len;
        logic [31:0] prev;
        logic [31:0] last;
    } vec_t;
    vec_t tbl[9];

    function automatic logic [31:0] hw(input logic [4:0] o, input logic [23:0] s);
        return {2'b00, 1'b1, o, s};
    endfunction

    function automatic logic [31:0] rw(input logic [4:0] o, input logic [23:0] s);
        return {exp_ill, exp_merr, 1'b1, o, s};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Entered just after a negedge: compare the current cycle, drive its inputs, advance one cycle
    task automatic step(input string name, input logic [31:0] exp, input logic mr, input logic stp);
        check(name, obs, exp);
        mem_ready = mr;
        Stop      = stp;
        @(negedge Clock);
    endtask

    task automatic push(input logic [31:0] w, input logic mr);
        exp_q.push_back(w);
        mr_q.push_back(mr);
    endtask

    task automatic push_halt();
        push({exp_ill, exp_merr, 30'b0}, 1'($urandom_range(0, 1)));
        push({exp_ill, exp_merr, 30'b0}, 1'($urandom_range(0, 1)));
        halted = 1'b1;
    endtask

    // Instruction as a list of micro-steps: fetch, then the opcode's execute steps
    task automatic build_trace(input logic [4:0] opc, input int waits);
        exp_q.delete();
        mr_q.delete();
        halted = 1'b0;
        push(rw(5'd0, PCO | MAR | INC | ZHI | ZLI), 1'($urandom_range(0, 1)));
        if (waits >= 15) begin
            for (int k = 0; k < 15; k++) push(rw(5'd0, RD | MDI | ((k == 0) ? (ZLO | PCI) : 24'd0)), 1'b0);
            exp_merr = 1'b1;
            push_halt();
            return;
        end
        for (int k = 0; k <= waits; k++) push(rw(5'd0, RD | MDI | ((k == 0) ? (ZLO | PCI) : 24'd0)), k == waits);
        push(rw(5'd0, MDO | IRI), 1'($urandom_range(0, 1)));
        case (opc)
            ADD, SUB, AND_, OR_: begin
                push(rw(5'd0, GB | ROUT | YI), 1'b0);
                push(rw(opc, GC | ROUT | ZHI | ZLI), 1'b1);
                push(rw(5'd0, ZLO | GA | RIN), 1'b0);
            end
            ADDI, ANDI, ORI: begin
                push(rw(5'd0, GB | BAO | YI), 1'b0);
                push(rw((opc == ADDI) ? ADD : (opc == ANDI) ? AND_ : OR_, CO | ZHI | ZLI), 1'b1);
                push(rw(5'd0, ZLO | GA | RIN), 1'b0);
            end
            MUL, DIV: begin
                push(rw(5'd0, GA | ROUT | YI), 1'b1);
                push(rw(opc, GB | ROUT | ZHI | ZLI), 1'b0);
                push(rw(5'd0, ZLO | LOI), 1'b1);
                push(rw(5'd0, ZHO | HII), 1'b0);
            end
            MFHI: push(rw(5'd0, HIO | GA | RIN), 1'b0);
            MFLO: push(rw(5'd0, LOO | GA | RIN), 1'b0);
            NOP: ;
            HLT: push_halt();
            default: begin
`ifdef CU_ILLEGAL_TRAP_EN
                exp_ill = 1'b1;
                push_halt();
`endif
            end
        endcase
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge Clock);
        exp_merr = 1'b0;
        exp_ill  = 1'b0;
        check("reset_state", obs, 32'd0);
        clear = 1'b0;
        @(negedge Clock);
    endtask

    task automatic run_instr(input logic [4:0] opc, input int waits, input logic stop_end, input int pause_len);
        logic [31:0] rnd;
        rnd = $urandom();
        ir  = {opc, rnd[26:0]};
        build_trace(opc, waits);
        for (int i = 0; i < exp_q.size(); i++)
            step($sformatf("op%b_cyc%0d", opc, i), exp_q[i], mr_q[i],
                 (i == exp_q.size() - 1) ? stop_end : 1'($urandom_range(0, 1)));
        if (halted) begin
            do_clear();
        end else if (stop_end) begin
            for (int p = 0; p < pause_len; p++)
                step("pause", {exp_ill, exp_merr, 30'b0}, 1'($urandom_range(0, 1)), p < pause_len - 1);
        end
    endtask

    logic [4:0] pool[16];

    initial begin
        tbl[0] = '{ADD,  0, 6, hw(ADD, GC | ROUT | ZHI | ZLI),  hw(5'd0, ZLO | GA | RIN)};
        tbl[1] = '{MFHI, 0, 4, hw(5'd0, MDO | IRI),             hw(5'd0, HIO | GA | RIN)};
        tbl[2] = '{MFLO, 0, 4, hw(5'd0, MDO | IRI),             hw(5'd0, LOO | GA | RIN)};
        tbl[3] = '{ADDI, 0, 6, hw(ADD, CO | ZHI | ZLI),         hw(5'd0, ZLO | GA | RIN)};
        tbl[4] = '{ANDI, 1, 7, hw(AND_, CO | ZHI | ZLI),        hw(5'd0, ZLO | GA | RIN)};
        tbl[5] = '{ADD,  3, 9, hw(ADD, GC | ROUT | ZHI | ZLI),  hw(5'd0, ZLO | GA | RIN)};
        tbl[6] = '{MUL,  0, 7, hw(5'd0, ZLO | LOI),             hw(5'd0, ZHO | HII)};
        tbl[7] = '{NOP,  0, 3, hw(5'd0, RD | MDI | ZLO | PCI),  hw(5'd0, MDO | IRI)};
        tbl[8] = '{DIV,  2, 9, hw(5'd0, ZLO | LOI),             hw(5'd0, ZHO | HII)};
        pool = '{ADD, SUB, AND_, OR_, ADDI, ANDI, ORI, MUL, DIV, MFHI, MFLO, NOP, HLT,
                 5'b00000, 5'b11111, 5'b10101};

        clear = 1'b1; mem_ready = 1'b1; Stop = 1'b0; ir = 32'h1811_8000;
        repeat (2) @(negedge Clock);
        check("reset_state", obs, 32'd0);
        clear = 1'b0;
        @(negedge Clock);

        // Directed lengths: count DUT cycles from T0 until the next T0
        foreach (tbl[t]) begin
            int cnt, reads;
            logic [31:0] prv, lst;
            cnt = 0; reads = 0; prv = '0; lst = '0;
            ir = {tbl[t].opc, 27'h0123};
            Stop = 1'b0;
            while (cnt < 40 && !(cnt > 0 && obs[0])) begin
                prv = lst;
                lst = obs;
                if (obs[4]) reads++;
                mem_ready = (reads > tbl[t].waits);
                @(negedge Clock);
                cnt++;
            end
            check_int($sformatf("tbl%0d_len", t), cnt, tbl[t].len);
            check($sformatf("tbl%0d_prev", t), prv, tbl[t].prev);
            check($sformatf("tbl%0d_last", t), lst, tbl[t].last);
        end

        run_instr(ADD, 3, 1'b0, 1);
        run_instr(MUL, 0, 1'b1, 1);
        run_instr(MUL, 0, 1'b1, 3);
        run_instr(SUB, 15, 1'b0, 1);
        run_instr(5'b11111, 0, 1'b0, 1);
        run_instr(OR_, 14, 1'b0, 1);
        run_instr(HLT, 0, 1'b0, 1);

        for (int r = 0; r < 60; r++) begin
            int w;
            w = ($urandom_range(0, 19) == 0) ? 15 : int'($urandom_range(0, 4));
            run_instr(pool[$urandom_range(0, 15)], w, $urandom_range(0, 3) == 0, int'($urandom_range(1, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
